// File: rtl/reg_req_fifo_bridge_pkg.sv
// Shared constants for the register-request FIFO bridge: default widths and FSM encodings.
package reg_req_fifo_bridge_pkg;

  localparam int unsigned ADDR_W_DEF         = 23;
  localparam int unsigned DATA_W_DEF         = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
  localparam logic [31:0] TIMEOUT_DATA_DEF   = 32'hDEAD_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

// File: rtl/reg_timeout_ctr.sv
// Counts ISSUE cycles; expire flags the last permitted cycle before the bridge aborts.
module reg_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = en && (cnt == LAST);

  // Holds at the threshold so the count can never wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_req_fifo_bridge.sv
// Pops register requests from the request FIFO, runs them on the local register bus with a
// timeout guard, and pushes one response per request into the response FIFO.
module reg_req_fifo_bridge
  import reg_req_fifo_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(TIMEOUT_DATA_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W+DATA_W:0]   req_rdata,
  input  logic                     req_rempty,
  output logic                     req_rinc,
  output logic                     reg_req,
  output logic                     reg_rd_wr_L,
  output logic [ADDR_W-1:0]        reg_addr,
  output logic [DATA_W-1:0]        reg_wr_data,
  input  logic                     reg_ack,
  input  logic [DATA_W-1:0]        reg_rd_data,
  output logic [ADDR_W+DATA_W+1:0] resp_wdata,
  output logic                     resp_winc,
  input  logic                     resp_wfull,
  output logic                     busy
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              expire;
  logic              issue_done;
  logic              resp_timeout;
  logic [DATA_W-1:0] resp_data;

  reg_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (state != ST_ISSUE),
    .en    (state == ST_ISSUE),
    .expire(expire)
  );

  assign issue_done = (state == ST_ISSUE) && (reg_ack || expire);
  assign busy       = (state != ST_IDLE) && !reset;
  assign resp_wdata = {resp_timeout, reg_rd_wr_L, reg_addr, resp_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO strobes are gated by reset so a dropped transaction never pops or pushes.
  always_comb begin
    state_nxt = state;
    req_rinc  = 1'b0;
    resp_winc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!req_rempty) begin
          req_rinc  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (reg_ack || expire) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!resp_wfull) begin
          resp_winc = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      req_rinc  = 1'b0;
      resp_winc = 1'b0;
    end
  end

  // Request holding registers double as the register-bus drive; an ack beats the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req      <= 1'b0;
      reg_rd_wr_L  <= 1'b0;
      reg_addr     <= '0;
      reg_wr_data  <= '0;
      resp_timeout <= 1'b0;
      resp_data    <= '0;
    end else if (req_rinc) begin
      {reg_rd_wr_L, reg_addr, reg_wr_data} <= req_rdata;
      reg_req <= 1'b1;
    end else if (issue_done) begin
      reg_req      <= 1'b0;
      resp_timeout <= !reg_ack;
      if (!reg_rd_wr_L) begin
        resp_data <= reg_wr_data;
      end else if (reg_ack) begin
        resp_data <= reg_rd_data;
      end else begin
        resp_data <= TIMEOUT_DATA;
      end
    end
  end

endmodule

// File: tb/tb_reg_req_fifo_bridge.sv
// Scoreboard bench: models the request FIFO, the register target and the response FIFO.
module tb_reg_req_fifo_bridge;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO_CYC = 8;

  typedef struct {
    logic [ADDR_W+DATA_W:0] entry;
    int                     ack_at;
    logic [DATA_W-1:0]      rd;
    int                     full;
  } req_t;

  logic                     clk;
  logic                     reset;
  logic [ADDR_W+DATA_W:0]   req_rdata;
  logic                     req_rempty;
  logic                     req_rinc;
  logic                     reg_req;
  logic                     reg_rd_wr_L;
  logic [ADDR_W-1:0]        reg_addr;
  logic [DATA_W-1:0]        reg_wr_data;
  logic                     reg_ack;
  logic [DATA_W-1:0]        reg_rd_data;
  logic [ADDR_W+DATA_W+1:0] resp_wdata;
  logic                     resp_winc;
  logic                     resp_wfull;
  logic                     busy;

  req_t                     req_q[$];
  logic [ADDR_W+DATA_W+1:0] exp_q[$];
  int                       pops[$];
  int                       lens[$];
  req_t                     cur;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_n = 0;
  int req_hi = 0;
  int full_cnt = 0;
  logic pop_pend = 1'b0;
  logic pop_prev = 1'b0;
  logic ack_prev = 1'b0;
  logic req_prev = 1'b0;

  reg_req_fifo_bridge #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TO_CYC),
    .TIMEOUT_DATA  (32'hDEAD_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_rdata  (req_rdata),
    .req_rempty (req_rempty),
    .req_rinc   (req_rinc),
    .reg_req    (reg_req),
    .reg_rd_wr_L(reg_rd_wr_L),
    .reg_addr   (reg_addr),
    .reg_wr_data(reg_wr_data),
    .reg_ack    (reg_ack),
    .reg_rd_data(reg_rd_data),
    .resp_wdata (resp_wdata),
    .resp_winc  (resp_winc),
    .resp_wfull (resp_wfull),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                      input int ack_at, input logic [DATA_W-1:0] rd, input int full);
    req_t r;
    logic to;
    r.entry  = {rw, addr, data};
    r.ack_at = ack_at;
    r.rd     = rd;
    r.full   = full;
    req_q.push_back(r);
    to = (ack_at == 0) || (ack_at > int'(TO_CYC));
    if (to) exp_q.push_back({1'b1, rw, addr, rw ? 32'hDEAD_0000 : data});
    else    exp_q.push_back({1'b0, rw, addr, rw ? rd : data});
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (req_q.size() == 0 && exp_q.size() == 0 && !busy) break;
    end
    chk({tag, "_drain"}, 64'(exp_q.size() + req_q.size()), 64'(0));
  endtask

  // FIFO/target model: drive inputs just after the edge, check outputs on the falling edge.
  initial begin : bus_model
    req_rempty  = 1'b1;
    req_rdata   = '0;
    reg_ack     = 1'b0;
    reg_rd_data = '0;
    resp_wfull  = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pop_pend) begin
        void'(req_q.pop_front());
        pop_pend = 1'b0;
      end
      req_rempty = (req_q.size() == 0);
      req_rdata  = req_rempty ? '0 : req_q[0].entry;
      if (ack_prev) full_cnt = cur.full;
      resp_wfull = (full_cnt > 0);
      if (full_cnt > 0) full_cnt--;
      reg_ack     = 1'b0;
      reg_rd_data = '0;
      if (reg_req && !reset) begin
        issue_n++;
        if (cur.ack_at == issue_n) begin
          reg_ack     = 1'b1;
          reg_rd_data = cur.rd;
        end
      end

      @(negedge clk);
      if (pop_prev) chk("req_rise", 64'(reg_req), 64'(1));
      pop_prev = req_rinc;
      if (req_rinc) begin
        cur      = req_q[0];
        pop_pend = 1'b1;
        pops.push_back(cyc);
        issue_n  = 0;
        req_hi   = 0;
      end
      if (reg_req) begin
        req_hi++;
        chk("issue_hold", 64'({reg_rd_wr_L, reg_addr, reg_wr_data}), 64'(cur.entry));
        if (!reset) chk("busy_issue", 64'(busy), 64'(1));
      end
      if (req_prev && !reg_req) lens.push_back(req_hi);
      req_prev = reg_req;
      if (ack_prev && !resp_wfull) chk("ack_to_winc", 64'(resp_winc), 64'(1));
      if (resp_wfull) begin
        chk("bp_no_winc", 64'(resp_winc), 64'(0));
        chk("bp_no_pop", 64'(req_rinc), 64'(0));
      end
      if (resp_winc) begin
        chk("push_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) chk("resp_wdata", 64'(resp_wdata), 64'(exp_q.pop_front()));
      end
      ack_prev = reg_ack;
    end
  end

  initial begin : main
    reset = 1'b1;
    send(1'b1, 23'h000010, 32'h0, 3, 32'hCAFE_F00D, 0);
    repeat (3) @(negedge clk);
    chk("rst_rinc", 64'(req_rinc), 64'(0));
    chk("rst_req", 64'(reg_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_winc", 64'(resp_winc), 64'(0));
    chk("rst_addr", 64'({reg_rd_wr_L, reg_addr, reg_wr_data}), 64'(0));
    chk("rst_resp", 64'(resp_wdata), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    wait_done("read", 50);

    send(1'b0, 23'h000020, 32'h1234_5678, 1, 32'h0, 0);
    wait_done("write", 50);

    pops.delete(); lens.delete();
    send(1'b1, 23'h000030, 32'h0, 0, 32'h0, 0);
    send(1'b0, 23'h000031, 32'hA5A5_0001, 1, 32'h0, 0);
    wait_done("timeout", 80);
    chk("to_req_len", 64'(lens.size() > 0 ? lens[0] : -1), 64'(TO_CYC));
    chk("to_pop_gap", 64'(pops.size() > 1 ? pops[1] - pops[0] : -1), 64'(TO_CYC + 2));

    send(1'b1, 23'h000040, 32'h0, 8, 32'h1111_2222, 0);
    wait_done("ack_at_limit", 80);

    pops.delete();
    send(1'b0, 23'h000050, 32'h0BAD_BEEF, 1, 32'h0, 5);
    send(1'b1, 23'h000051, 32'h0, 2, 32'h5555_AAAA, 0);
    wait_done("backpressure", 80);
    chk("bp_pop_gap", 64'(pops.size() > 1 ? pops[1] - pops[0] : -1), 64'(8));

    pops.delete();
    for (int i = 0; i < 4; i++)
      send(1'b0, 23'(32'h60 + i), 32'h7000_0000 + 32'(i), 1, 32'h0, 0);
    wait_done("b2b", 80);
    for (int i = 1; i < 4; i++)
      chk("b2b_gap", 64'(pops.size() > i ? pops[i] - pops[i-1] : -1), 64'(3));

    send(1'b1, 23'h000070, 32'h0, 0, 32'h0, 0);
    send(1'b1, 23'h000071, 32'h0, 2, 32'hFEED_0071, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (req_hi == 2) break;
    end
    chk("rst_mid_reached", 64'(req_hi), 64'(2));
    @(posedge clk); #1;
    reset = 1'b1;
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_req", 64'(reg_req), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    wait_done("after_reset", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
